// File: rtl/mf_pair_seq.sv
// mf_pair_seq: sequencer for a one-bit parallel matched filter.
// Time-shares one external 2-tap lookup table across all tap pairs of a
// TAPS-long one-bit delay line, accumulating one partial sum per cycle.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready     sample handshake, in_bit is the one-bit sample
//   flush                 clears the delay line, honoured only while idle
//   coef_en, coef_sign    per-tap enable mask and sign, captured on accept
//   table_in/table_out    address {en1,d1,en0,d0} and signed result of the table
//   out_valid/out_ready   result handshake, out_data is the signed filter result
//   busy                  high while a sample is being processed or presented
module mf_pair_seq #(
    parameter int unsigned TAPS  = 16,
    parameter int unsigned TBL_W = 17,
    parameter int unsigned ACC_W = 24,
    parameter int unsigned IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             flush,
    input  logic [TAPS-1:0]  coef_en,
    input  logic [TAPS-1:0]  coef_sign,
    output logic [3:0]       table_in,
    input  logic [TBL_W-1:0] table_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy
);

    localparam int unsigned PAIRS = TAPS / 2;
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(PAIRS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state;
    logic [TAPS-1:0]   dl;
    logic [TAPS-1:0]   cfg_en;
    logic [TAPS-1:0]   cfg_sign;
    logic [ACC_W-1:0]  acc;
    logic [IDX_W-1:0]  k;

    logic [TAPS-1:0]   d;
    logic [3:0]        pair_addr;
    logic [ACC_W-1:0]  acc_next;

    // Sign is folded into the data bit so the table only needs the +/-DATA rule.
    assign d = dl ^ cfg_sign;

    always_comb begin
        pair_addr = '0;
        for (int unsigned p = 0; p < PAIRS; p++) begin
            if (k == IDX_W'(p)) begin
                pair_addr = {cfg_en[2*p+1], d[2*p+1], cfg_en[2*p], d[2*p]};
            end
        end
    end

    assign table_in = (state == StRun) ? pair_addr : 4'b0000;
    assign acc_next = acc + {{(ACC_W - TBL_W){table_out[TBL_W-1]}}, table_out};
    assign in_ready = (state == StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            dl        <= '0;
            cfg_en    <= '0;
            cfg_sign  <= '0;
            acc       <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    // A sample and a flush in the same cycle: the shift wins.
                    if (in_valid) begin
                        dl       <= {dl[TAPS-2:0], in_bit};
                        cfg_en   <= coef_en;
                        cfg_sign <= coef_sign;
                        acc      <= '0;
                        k        <= '0;
                        busy     <= 1'b1;
                        state    <= StRun;
                    end else if (flush) begin
                        dl <= '0;
                    end
                end
                StRun: begin
                    acc <= acc_next;
                    if (k == LAST_K) begin
                        k         <= '0;
                        out_valid <= 1'b1;
                        out_data  <= acc_next;
                        state     <= StDone;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mf_pair_seq.sv
// Self-checking bench for mf_pair_seq with a behavioural handshake-level model.
module tb_mf_pair_seq;

    localparam int TAPS  = 16;
    localparam int PAIRS = TAPS / 2;
    localparam int DATA  = 100;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_bit;
    logic        flush;
    logic [15:0] coef_en;
    logic [15:0] coef_sign;
    logic [3:0]  table_in;
    logic [16:0] table_out;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mf_pair_seq #(
        .TAPS (16),
        .TBL_W(17),
        .ACC_W(24),
        .IDX_W(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bit   (in_bit),
        .flush    (flush),
        .coef_en  (coef_en),
        .coef_sign(coef_sign),
        .table_in (table_in),
        .table_out(table_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    // External 2-tap table: bit 0 -> +DATA, bit 1 -> -DATA, disabled -> 0.
    function automatic int tv(input logic en, input logic dbit);
        return en ? (dbit ? -DATA : DATA) : 0;
    endfunction

    assign table_out = 17'(tv(table_in[3], table_in[2]) + tv(table_in[1], table_in[0]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_dl, m_en, m_sg;
    logic        m_busy, m_valid;
    longint      m_data, m_exp;
    int          m_cnt;

    function automatic longint fsum(input logic [15:0] dlv, input logic [15:0] en,
                                    input logic [15:0] sg);
        longint s = 0;
        for (int i = 0; i < TAPS; i++) s += tv(en[i], dlv[i] ^ sg[i]);
        return s;
    endfunction

    function automatic logic [3:0] paddr(input int p);
        logic [15:0] dv;
        dv = m_dl ^ m_sg;
        return {m_en[2*p+1], dv[2*p+1], m_en[2*p], dv[2*p]};
    endfunction

    initial begin
        m_dl = '0; m_en = '0; m_sg = '0;
        m_busy = 1'b0; m_valid = 1'b0; m_data = 0; m_exp = 0; m_cnt = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_dl = '0; m_en = '0; m_sg = '0;
                m_busy = 1'b0; m_valid = 1'b0; m_data = 0; m_cnt = 0;
            end else if (m_valid) begin
                if (out_ready) begin
                    m_valid = 1'b0;
                    m_busy  = 1'b0;
                end
            end else if (m_busy) begin
                m_cnt++;
                if (m_cnt == PAIRS) begin
                    m_valid = 1'b1;
                    m_data  = m_exp;
                    m_cnt   = 0;
                end
            end else if (in_valid) begin
                m_dl   = {m_dl[14:0], in_bit};
                m_en   = coef_en;
                m_sg   = coef_sign;
                m_exp  = fsum(m_dl, m_en, m_sg);
                m_busy = 1'b1;
                m_cnt  = 0;
            end else if (flush) begin
                m_dl = '0;
            end
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("in_ready", in_ready, !m_busy && !m_valid);
            chk("busy", busy, m_busy);
            chk("out_valid", out_valid, m_valid);
            chk("out_data", $signed(out_data), m_data);
            chk("table_in", table_in, (m_busy && !m_valid) ? paddr(m_cnt) : 4'b0000);
        end
    end

    // ---------------- driver ----------------
    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic accept(input logic b, input logic [15:0] en, input logic [15:0] sg,
                          input logic fl);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick;
            n++;
        end
        if (n >= 100) chk("accept_timeout", n, 0);
        in_valid  = 1'b1;
        in_bit    = b;
        coef_en   = en;
        coef_sign = sg;
        flush     = fl;
        tick;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick;
            lat++;
        end
        if (lat >= 100) chk("result_timeout", lat, 0);
    endtask

    task automatic run_one(input logic b, input logic [15:0] en, input logic [15:0] sg,
                           output longint res);
        int lat;
        accept(b, en, sg, 1'b0);
        wait_result(lat);
        res = $signed(out_data);
        tick;
    endtask

    initial begin
        int     lat;
        longint res;
        longint held;

        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; flush = 1'b0;
        coef_en = '0; coef_sign = '0; out_ready = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_table_in", table_in, 0);
        chk("rst_busy", busy, 0);
        tick; tick;
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Latency and table address sequence for a single one.
        accept(1'b1, 16'hFFFF, 16'h0000, 1'b0);
        chk("addr_pair0", table_in, 4'b1011);
        tick;
        chk("addr_pair1", table_in, 4'b1010);
        wait_result(lat);
        chk("latency", lat + 1, PAIRS);
        chk("ones1", $signed(out_data), 1400);
        tick;
        for (int i = 0; i < 15; i++) run_one(1'b1, 16'hFFFF, 16'h0000, res);
        chk("ones16", res, -1600);

        // Mask and cancellation.
        flush = 1'b1; tick; flush = 1'b0;
        run_one(1'b1, 16'h0003, 16'h0000, res);
        chk("mask_cancel", res, 0);
        flush = 1'b1; tick; flush = 1'b0;
        run_one(1'b1, 16'h0003, 16'h0001, res);
        chk("mask_sign", res, 200);

        // Backpressure with a competing sample held on the input.
        out_ready = 1'b0;
        accept(1'b0, 16'hFFFF, 16'h0000, 1'b0);
        wait_result(lat);
        held = $signed(out_data);
        in_valid = 1'b1; in_bit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("bp_valid", out_valid, 1);
            chk("bp_data", $signed(out_data), held);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1; in_valid = 1'b0;
        tick;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);

        // Config capture: sign change mid-run is ignored.
        flush = 1'b1; tick; flush = 1'b0;
        accept(1'b0, 16'hFFFF, 16'h0000, 1'b0);
        tick; tick; tick;
        coef_sign = 16'hFFFF;
        wait_result(lat);
        chk("cfg_capture", $signed(out_data), 1600);
        tick;

        // Reset in the middle of a run.
        accept(1'b1, 16'hFFFF, 16'h0000, 1'b0);
        tick; tick; tick; tick;
        rst = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_table", table_in, 0);
        chk("midrst_data", out_data, 0);
        tick;
        rst = 1'b0;
        run_one(1'b0, 16'hFFFF, 16'h0000, res);
        chk("after_rst", res, 1600);

        // Flush in idle, then flush together with a sample.
        for (int i = 0; i < 3; i++) run_one(1'b1, 16'hFFFF, 16'h0000, res);
        flush = 1'b1; tick; flush = 1'b0;
        run_one(1'b0, 16'hFFFF, 16'h0000, res);
        chk("after_flush", res, 1600);
        accept(1'b1, 16'hFFFF, 16'h0000, 1'b1);
        wait_result(lat);
        chk("flush_and_valid", $signed(out_data), 1400);
        tick;

        // Randomized traffic checked against the model.
        for (int i = 0; i < 4000; i++) begin
            in_valid  = ($urandom_range(0, 2) == 0);
            in_bit    = 1'($urandom);
            coef_en   = 16'($urandom);
            coef_sign = 16'($urandom);
            flush     = ($urandom_range(0, 7) == 0);
            out_ready = 1'($urandom);
            tick;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20; i++) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mf_pair_seq.md
Name: mf_pair_seq

Overview:
- Sequencer for the one-bit parallel matched filter. It time-shares one external 2-tap lookup table (4-bit address {en1,d1,en0,d0}, signed 17-bit partial sum) across all tap pairs of a TAPS-long one-bit delay line.
- Each accepted input sample shifts the delay line. The block then walks TAPS/2 table addresses, accumulates the returned partial sums, and presents one filter output under a valid/ready handshake.

Parameters:
- TAPS, 16, delay-line length; even, >= 2.
- TBL_W, 17, width of the signed table output.
- ACC_W, 24, accumulator/output width; must be >= TBL_W + clog2(TAPS/2).
- IDX_W, 3, pair-index width; must be >= clog2(TAPS/2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_bit  in  1  one-bit sample.
- flush  in  1  clear the delay line; honoured only in IDLE.
- coef_en  in  TAPS  per-tap enable mask.
- coef_sign  in  TAPS  per-tap coefficient sign; XORed with the sample bit.
- table_in  out  4  address to the external table: {en[2k+1], d[2k+1], en[2k], d[2k]}.
- table_out  in  TBL_W  signed combinational table result for table_in.
- out_valid  out  1  filter result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_W  signed filter result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst=1): state=IDLE; delay line dl=0; acc=0; pair index k=0; captured cfg=0; out_valid=0; out_data=0; table_in=0; busy=0; in_ready=1 as soon as rst is released.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, table_in=0.
  - On in_valid at an edge:
    - dl <= {dl[TAPS-2:0], in_bit}, so dl[0] is the newest sample.
    - capture coef_en and coef_sign into cfg registers; later changes are ignored until the next accept.
    - acc<=0; k<=0; go to RUN.
  - If flush=1 with no in_valid: dl<=0 and stay in IDLE. If flush and in_valid arrive together: the shift wins, flush is ignored.
- RUN:
  - in_ready=0, in_valid ignored.
  - Combinationally, d[i] = dl[i] ^ sign[i] and table_in = {en[2k+1], d[2k+1], en[2k], d[2k]}.
  - Each edge: acc <= acc + sign-extended table_out; k<=k+1.
  - On the edge where k==TAPS/2-1: go to DONE and k<=0.
- DONE:
  - out_valid=1, out_data=acc, table_in=0, in_ready=0.
  - Hold everything while out_ready=0.
  - On out_ready=1: go to IDLE. out_valid drops the next cycle; out_data keeps its last value.
- Latency: out_valid is high exactly TAPS/2 cycles after the accepting edge. Throughput is one sample per TAPS/2+2 cycles at best.
- Arithmetic:
  - Two's complement; table_out is sign-extended to ACC_W.
  - No saturation is needed when ACC_W meets its constraint.
  - Table convention: data bit 0 gives +DATA, data bit 1 gives -DATA, a disabled tap gives 0.
- Reset mid-RUN or mid-DONE: immediately IDLE; acc, dl and outputs return to their reset values; no partial result is emitted.

Test Plan (TAPS=16, external table with DATA=100):
1. Reset: assert rst mid-cycle -> out_valid=0, out_data=0, table_in=0, busy=0 immediately; in_ready=1 after release.
2. Latency and all-ones: coef_en=16'hFFFF, coef_sign=0, dl=0 after reset.
   - Send in_bit=1 -> table_in sequence 4'b1011, then 4'b1010 x7; out_valid rises 8 cycles after accept; out_data=1400.
   - After 16 ones total, out_data=-1600.
3. Mask and cancellation: coef_en=16'h0003, sign=0, dl[1:0]=2'b01 -> pair 0 address 4'b1011 -> 0; all other pairs disabled; out_data=0.
   - With coef_sign=16'h0001, same data -> address 4'b1010 -> out_data=200.
4. Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> out_valid and out_data stable, in_ready=0, dl unchanged; when out_ready=1, handshake completes and IDLE returns next cycle.
5. Config capture: change coef_sign to 16'hFFFF at k=3 of a RUN -> result equals the value computed with the sign captured at accept.
6. Reset and flush:
   - rst at k=4 -> IDLE next, dl=0; the next all-zero-data output with full mask is 1600.
   - flush in IDLE after ones -> dl=0, same 1600 result.
   - flush together with in_valid -> shift only.
